// File: rtl/if_id_queue_pkg.sv
// Shared pipeline constants for the fetch/decode boundary queue.
// Holds the NOP encoding and the default queue depth.
package if_id_queue_pkg;

  localparam int unsigned IFQ_DEPTH = 2;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned IFQ_ENTRY_W = 64;

endpackage

// File: rtl/if_id_queue_entry_ram.sv
// Entry storage for the IF/ID queue: one sync write, one async read.
// Contents are qualified by the control pointers, so no reset here.
module ifid_entry_ram
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [IFQ_ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [IFQ_ENTRY_W-1:0] rdata
);

  logic [IFQ_ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: fetch pushes on hit, decode pops on ready,
// a taken branch flushes everything; also counts miss cycles.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] inst,
  input  logic [31:0] pcPlusFour,
  input  logic        hit,
  input  logic        PCSrc,
  input  logic        idReady,
  output logic [31:0] idInst,
  output logic [31:0] idPcPlusFour,
  output logic        idValid,
  output logic        fetchStall,
  output logic [15:0] missCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          full_q, full_d;
  logic [15:0]   miss_q, miss_d;

  logic          push;
  logic          pop;
  logic          valid;
  logic [63:0]   rdata;

  assign valid = (occ_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    miss_d   = miss_q;
    push     = hit && !full_q && !PCSrc;
    pop      = valid && idReady && !PCSrc;

    if (!hit && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'd1;
    end

    if (PCSrc) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        occ_d = occ_q + OW'(1);
      end else if (pop && !push) begin
        occ_d = occ_q - OW'(1);
      end
    end

    // Registered so fetch never sees a path from idReady or hit.
    full_d = (occ_d == OW'(DEPTH));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      miss_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      miss_q   <= miss_d;
    end
  end

  ifid_entry_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (Clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({pcPlusFour, inst}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign idValid      = valid;
  assign idInst       = valid ? rdata[31:0]  : NOP;
  assign idPcPlusFour = valid ? rdata[63:32] : 32'h0;
  assign fetchStall   = full_q;
  assign missCount    = miss_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed and model-based bench for the IF/ID queue (DEPTH=2).
// Inputs change 1ns after the rising edge; outputs are checked there.
module tb_if_id_queue;

  localparam int DEPTH = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] inst;
  logic [31:0] pcPlusFour;
  logic        hit;
  logic        PCSrc;
  logic        idReady;
  logic [31:0] idInst;
  logic [31:0] idPcPlusFour;
  logic        idValid;
  logic        fetchStall;
  logic [15:0] missCount;

  int n_pass = 0;
  int n_total = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .inst         (inst),
    .pcPlusFour   (pcPlusFour),
    .hit          (hit),
    .PCSrc        (PCSrc),
    .idReady      (idReady),
    .idInst       (idInst),
    .idPcPlusFour (idPcPlusFour),
    .idValid      (idValid),
    .fetchStall   (fetchStall),
    .missCount    (missCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    hit = 1'b0;
    PCSrc = 1'b0;
    idReady = 1'b0;
    inst = '0;
    pcPlusFour = '0;
    tick();
    Rst = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] p);
    hit = 1'b1;
    inst = w;
    pcPlusFour = p;
    tick();
    hit = 1'b0;
  endtask

  task automatic test_reset();
    hit = 1'b1;
    inst = 32'h1111_1111;
    pcPlusFour = 32'h10;
    tick();
    do_reset();
    n_total++;
    if ({idValid, fetchStall} !== 2'b00) begin
      $display("FAIL reset_flags: got v=%b s=%b want 0 0", idValid, fetchStall);
    end else n_pass++;
    n_total++;
    if (idInst !== 32'h0 || idPcPlusFour !== 32'h0) begin
      $display("FAIL reset_data: got %h/%h want 0/0", idInst, idPcPlusFour);
    end else n_pass++;
    n_total++;
    if (missCount !== 16'h0) begin
      $display("FAIL reset_miss: got %h want 0", missCount);
    end else n_pass++;
  endtask

  task automatic test_single_push();
    do_reset();
    push_word(32'h2008_0005, 32'h4);
    n_total++;
    if (idValid !== 1'b1 || idInst !== 32'h2008_0005 ||
        idPcPlusFour !== 32'h4 || fetchStall !== 1'b0) begin
      $display("FAIL single_push: got v=%b %h/%h s=%b want 1 20080005/4 0",
               idValid, idInst, idPcPlusFour, fetchStall);
    end else n_pass++;
    idReady = 1'b1;
    tick();
    idReady = 1'b0;
    n_total++;
    if (idValid !== 1'b0 || idInst !== 32'h0) begin
      $display("FAIL single_pop: got v=%b %h want 0 0", idValid, idInst);
    end else n_pass++;
  endtask

  task automatic test_full_drop();
    do_reset();
    push_word(32'hA000_0001, 32'h8);
    push_word(32'hA000_0002, 32'hC);
    n_total++;
    if (fetchStall !== 1'b1) begin
      $display("FAIL full_stall: got %b want 1", fetchStall);
    end else n_pass++;
    push_word(32'hA000_0003, 32'h10);
    n_total++;
    if (fetchStall !== 1'b1 || idInst !== 32'hA000_0001 ||
        idPcPlusFour !== 32'h8) begin
      $display("FAIL full_head1: got s=%b %h/%h want 1 a0000001/8",
               fetchStall, idInst, idPcPlusFour);
    end else n_pass++;
    idReady = 1'b1;
    tick();
    n_total++;
    if (idValid !== 1'b1 || idInst !== 32'hA000_0002 ||
        idPcPlusFour !== 32'hC || fetchStall !== 1'b0) begin
      $display("FAIL full_head2: got v=%b %h/%h s=%b want 1 a0000002/c 0",
               idValid, idInst, idPcPlusFour, fetchStall);
    end else n_pass++;
    tick();
    idReady = 1'b0;
    n_total++;
    if (idValid !== 1'b0) begin
      $display("FAIL full_dropped: got v=%b %h want empty", idValid, idInst);
    end else n_pass++;
  endtask

  task automatic test_full_pop_push();
    do_reset();
    push_word(32'hB000_0001, 32'h14);
    push_word(32'hB000_0002, 32'h18);
    idReady = 1'b1;
    push_word(32'hB000_0003, 32'h1C);
    idReady = 1'b0;
    n_total++;
    if (idValid !== 1'b1 || fetchStall !== 1'b0 ||
        idInst !== 32'hB000_0002) begin
      $display("FAIL popfull: got v=%b s=%b %h want 1 0 b0000002",
               idValid, fetchStall, idInst);
    end else n_pass++;
    idReady = 1'b1;
    tick();
    idReady = 1'b0;
    n_total++;
    if (idValid !== 1'b0) begin
      $display("FAIL popfull_occ1: got v=%b %h want empty", idValid, idInst);
    end else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    push_word(32'hC000_0001, 32'h20);
    push_word(32'hC000_0002, 32'h24);
    PCSrc = 1'b1;
    push_word(32'hC000_0003, 32'h28);
    PCSrc = 1'b0;
    n_total++;
    if (idValid !== 1'b0 || idInst !== 32'h0 || idPcPlusFour !== 32'h0 ||
        fetchStall !== 1'b0) begin
      $display("FAIL flush: got v=%b %h/%h s=%b want 0 0/0 0",
               idValid, idInst, idPcPlusFour, fetchStall);
    end else n_pass++;
    push_word(32'hC000_0004, 32'h80);
    n_total++;
    if (idValid !== 1'b1 || idInst !== 32'hC000_0004 ||
        idPcPlusFour !== 32'h80) begin
      $display("FAIL flush_push: got v=%b %h/%h want 1 c0000004/80",
               idValid, idInst, idPcPlusFour);
    end else n_pass++;
    idReady = 1'b1;
    tick();
    idReady = 1'b0;
    n_total++;
    if (idValid !== 1'b0) begin
      $display("FAIL flush_alone: got v=%b %h want empty", idValid, idInst);
    end else n_pass++;
  endtask

  task automatic test_empty_ready();
    do_reset();
    idReady = 1'b1;
    tick();
    n_total++;
    if (idValid !== 1'b0 || idInst !== 32'h0 || fetchStall !== 1'b0) begin
      $display("FAIL empty_ready: got v=%b %h s=%b want 0 0 0",
               idValid, idInst, fetchStall);
    end else n_pass++;
    push_word(32'hD000_0001, 32'h30);
    n_total++;
    if (idValid !== 1'b1 || idInst !== 32'hD000_0001) begin
      $display("FAIL empty_push: got v=%b %h want 1 d0000001", idValid, idInst);
    end else n_pass++;
    tick();
    idReady = 1'b0;
    n_total++;
    if (idValid !== 1'b0) begin
      $display("FAIL empty_drain: got v=%b want 0", idValid);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_word(32'hE000_0001, 32'h40);
    idReady = 1'b1;
    push_word(32'hE000_0002, 32'h44);
    n_total++;
    if (idValid !== 1'b1 || idInst !== 32'hE000_0002 ||
        idPcPlusFour !== 32'h44 || fetchStall !== 1'b0) begin
      $display("FAIL b2b_1: got v=%b %h/%h s=%b want 1 e0000002/44 0",
               idValid, idInst, idPcPlusFour, fetchStall);
    end else n_pass++;
    push_word(32'hE000_0003, 32'h48);
    n_total++;
    if (idValid !== 1'b1 || idInst !== 32'hE000_0003 || fetchStall !== 1'b0) begin
      $display("FAIL b2b_2: got v=%b %h s=%b want 1 e0000003 0",
               idValid, idInst, fetchStall);
    end else n_pass++;
    tick();
    idReady = 1'b0;
    n_total++;
    if (idValid !== 1'b0) begin
      $display("FAIL b2b_drain: got v=%b want 0", idValid);
    end else n_pass++;
  endtask

  task automatic test_miss_sat();
    do_reset();
    repeat (5) tick();
    n_total++;
    if (missCount !== 16'd5) begin
      $display("FAIL miss_count5: got %0d want 5", missCount);
    end else n_pass++;
    repeat (69995) @(posedge Clk);
    #1;
    n_total++;
    if (missCount !== 16'hFFFF) begin
      $display("FAIL miss_sat: got %h want ffff", missCount);
    end else n_pass++;
    repeat (10) tick();
    n_total++;
    if (missCount !== 16'hFFFF) begin
      $display("FAIL miss_hold: got %h want ffff", missCount);
    end else n_pass++;
    do_reset();
    n_total++;
    if (missCount !== 16'h0) begin
      $display("FAIL miss_rst: got %h want 0", missCount);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] seq;
    logic [31:0] exp_inst, exp_pc;
    logic        exp_v, exp_s, do_pop, do_push;
    int          fails;
    fails = 0;
    seq = 32'h100;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      exp_v = (q.size() > 0);
      exp_s = (q.size() == DEPTH);
      exp_inst = exp_v ? q[0][31:0] : 32'h0;
      exp_pc = exp_v ? q[0][63:32] : 32'h0;
      n_total++;
      if (idValid !== exp_v || fetchStall !== exp_s ||
          idInst !== exp_inst || idPcPlusFour !== exp_pc) begin
        if (fails < 10) begin
          $display("FAIL rand_c%0d: got v=%b s=%b %h/%h want %b %b %h/%h",
                   i, idValid, fetchStall, idInst, idPcPlusFour,
                   exp_v, exp_s, exp_inst, exp_pc);
        end
        fails++;
      end else n_pass++;
      hit = ($urandom_range(0, 3) != 0);
      idReady = ($urandom_range(0, 2) != 0);
      PCSrc = ($urandom_range(0, 9) == 0);
      inst = seq;
      pcPlusFour = seq << 2;
      do_pop = exp_v && idReady && !PCSrc;
      do_push = hit && !exp_s && !PCSrc;
      if (PCSrc) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({seq << 2, seq});
      end
      seq++;
      tick();
    end
    hit = 1'b0;
    idReady = 1'b0;
    PCSrc = 1'b0;
  endtask

  initial begin
    Rst = 1'b0;
    hit = 1'b0;
    PCSrc = 1'b0;
    idReady = 1'b0;
    inst = '0;
    pcPlusFour = '0;
    test_reset();
    test_single_push();
    test_full_drop();
    test_full_pop_push();
    test_flush();
    test_empty_ready();
    test_back_to_back();
    test_random();
    test_miss_sat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of queue entries (power of two, at least 2).
REQ-002 The block SHALL have port Clk  input  1  meaning the single rising-edge clock.
REQ-003 The block SHALL have port Rst  input  1  meaning a synchronous, active-high reset.
REQ-004 The block SHALL have port inst  input  32  meaning the instruction word from the fetch-stage L1 cache.
REQ-005 The block SHALL have port pcPlusFour  input  32  meaning the PC+4 of that instruction from fetch.
REQ-006 The block SHALL have port hit  input  1  meaning inst and pcPlusFour are valid this cycle.
REQ-007 The block SHALL have port PCSrc  input  1  meaning a taken branch or redirect, so the queue is flushed.
REQ-008 The block SHALL have port idReady  input  1  meaning decode accepts the head entry this cycle.
REQ-009 The block SHALL have port idInst  output  32  meaning the head instruction, or NOP when empty.
REQ-010 The block SHALL have port idPcPlusFour  output  32  meaning the head PC+4, or 0 when empty.
REQ-011 The block SHALL have port idValid  output  1  meaning the head entry is valid.
REQ-012 The block SHALL have port fetchStall  output  1  meaning the queue is full and fetch must hold its PC.
REQ-013 The block SHALL have port missCount  output  16  meaning the saturating count of cycles with hit=0.

Function
REQ-014 The block SHALL push an entry only when hit=1, the queue is not full, and PCSrc=0.
REQ-015 The block SHALL pop the head only when idValid=1, idReady=1, and PCSrc=0.
REQ-016 The block SHALL present a pushed entry on idInst/idPcPlusFour in the cycle after the push edge, with a minimum latency of 1 cycle.
REQ-017 The block SHALL update correctly on a simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
REQ-018 The block SHALL ignore a push while full, even if a pop occurs the same cycle, and SHALL NOT give fetch a credit in the same cycle.
REQ-019 The block SHALL drive fetchStall directly from a register equal to (occupancy==DEPTH), with no combinational path from idReady or hit.
REQ-020 The block SHALL set occupancy to 0 and discard all entries, including any entry pushed that cycle, on PCSrc=1; PCSrc overrides push and pop.
REQ-021 The block SHALL give idValid=0 in the cycle after a flush, and SHALL accept a push in the cycle after a flush.
REQ-022 The block SHALL drive idInst=32'h0000_0000 (MIPS NOP) and idPcPlusFour=0 whenever idValid=0.
REQ-023 The block SHALL use read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and an occupancy counter of log2(DEPTH)+1 bits.
REQ-024 The block SHALL increment missCount on every cycle with hit=0, including during a flush, and SHALL saturate missCount at 16'hFFFF.
REQ-025 The block SHALL leave outputs unaffected by an idReady assertion while empty.

Reset
REQ-026 The block SHALL, on Rst=1 at a Clk edge, clear pointers, occupancy and missCount, giving idValid=0, fetchStall=0, idInst=NOP, idPcPlusFour=0 and missCount=0 in the next cycle.
REQ-027 The block SHALL give Rst priority over PCSrc, push and pop, and a reset mid-stream SHALL discard all stored entries.
REQ-028 The block SHALL NOT require entry storage to be reset, because only the pointers and occupancy qualify its contents.

Structure
REQ-029 The NOP constant (32'h0000_0000) and the DEPTH default SHALL reside in the shared pipeline package.
REQ-030 Entry storage SHALL be a single sub-module, ifid_entry_ram: DEPTH x 64 bits, one synchronous write port, one asynchronous read port.
REQ-031 Control (pointers, occupancy, flush, miss counter) SHALL reside in if_id_queue itself.

Verification
REQ-032 The bench SHALL cover this scenario: reset, then hit=1 with inst=32'h2008_0005 and pcPlusFour=32'h0000_0004, idReady=0 -> the next cycle gives idValid=1, idInst=32'h2008_0005, idPcPlusFour=4, fetchStall=0.
REQ-033 The bench SHALL cover this scenario: three consecutive hits with DEPTH=2 and idReady=0 -> fetchStall=1 after the second push, the third word is dropped, and the queue holds words 1 and 2 in order.
REQ-034 The bench SHALL cover this scenario: a full queue with idReady=1 and hit=1 in the same cycle -> the pop occurs, the push is ignored, and the next cycle gives occupancy 1 and fetchStall=0.
REQ-035 The bench SHALL cover this scenario: two entries queued, then PCSrc=1 with hit=1 -> the next cycle gives idValid=0 and idInst=0, and a push one cycle later appears alone at the head.
REQ-036 The bench SHALL cover this scenario: hit=0 held for 70000 cycles -> missCount=16'hFFFF and stays there, and Rst=1 then gives missCount=0.
REQ-037 The bench SHALL cover this scenario: 1000 cycles of random hit, idReady and PCSrc against a reference model -> popped sequences match in order, with no duplicates and no wrong-path entries after any flush.
